// File: rtl/rreg_hold_mux.sv
// N-channel registered read-back mux: synchronised selects, priority capture, hold-until-release, one-shot ack.
// Optional feature macro: COLLISION_DETECT_EN (sticky multi-select flag).
module rreg_hold_mux #(
    parameter int              WIDTH       = 8,
    parameter int              CHANNELS    = 4,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_FILL  = '0,
    localparam int             CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       sel,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [WIDTH-1:0]          o,
    output logic                      valid,
    output logic [CW-1:0]             active_ch,
    output logic [CHANNELS-1:0]       ack,
    input  logic                      clr_collision,
    output logic                      collision,
    output logic [1:0]                o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                               r_state;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
    logic [WIDTH-1:0]                     r_o;
    logic                                 r_valid;
    logic [CW-1:0]                        r_ch;
    logic [CHANNELS-1:0]                  r_ack;

    logic [CHANNELS-1:0]                  w_s;
    logic                                 w_any;
    logic [CW-1:0]                        w_idx;
    logic [WIDTH-1:0]                     w_data;
    logic [CHANNELS-1:0]                  w_onehot;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_any    = |w_s;
    // Isolate the lowest set select bit: that channel wins arbitration.
    assign w_onehot = w_s & (~w_s + CHANNELS'(1));

    always_comb begin
        w_idx  = '0;
        w_data = IDLE_FILL;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_s[i]) begin
                w_idx  = CW'(i);
                w_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_state <= ST_IDLE;
            r_o     <= IDLE_FILL;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_ack   <= '0;
        end else begin
            r_sync[0] <= sel;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_o     <= IDLE_FILL;
                    r_valid <= 1'b0;
                    if (w_any) begin
                        r_o     <= w_data;
                        r_ch    <= w_idx;
                        r_valid <= 1'b1;
                        r_ack   <= w_onehot;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Only the captured channel's select can release the hold.
                    if (!w_s[r_ch]) begin
                        r_o     <= IDLE_FILL;
                        r_valid <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_o     <= IDLE_FILL;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_o     <= IDLE_FILL;
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o           = r_o;
    assign valid       = r_valid;
    assign active_ch   = r_ch;
    assign ack         = r_ack;
    assign o_dbg_state = r_state;

`ifdef COLLISION_DETECT_EN
    logic r_coll;
    logic w_multi;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign w_multi = (w_s & (w_s - CHANNELS'(1))) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll <= 1'b0;
        end else if (w_multi) begin
            r_coll <= 1'b1;
        end else if (clr_collision) begin
            r_coll <= 1'b0;
        end
    end

    assign collision = r_coll;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_collision;
    assign collision    = 1'b0;
`endif

endmodule

// File: tb/tb_rreg_hold_mux.sv
// Directed bench for rreg_hold_mux (WIDTH=8, CHANNELS=4, SYNC_STAGES=2, IDLE_FILL=0).
// Cycle-by-cycle vector table plus hand sequences for long hold and the collision flag.
module tb_rreg_hold_mux;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [CH-1:0]   sel;
    logic [CH*W-1:0] d;
    logic            clr_collision;
    logic [W-1:0]    o;
    logic            valid;
    logic [CW-1:0]   active_ch;
    logic [CH-1:0]   ack;
    logic            collision;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic            rst;
        logic [CH-1:0]   sel;
        logic [CH*W-1:0] d;
        logic [W-1:0]    exp_o;
        logic            exp_v;
        logic [CW-1:0]   exp_ch;
        logic [CH-1:0]   exp_ack;
        logic [1:0]      exp_st;
    } vec_t;

    vec_t vecs[$];

    rreg_hold_mux #(
        .WIDTH(W), .CHANNELS(CH), .SYNC_STAGES(2), .IDLE_FILL(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .d(d),
        .o(o), .valid(valid), .active_ch(active_ch), .ack(ack),
        .clr_collision(clr_collision), .collision(collision),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [CH-1:0] s, input logic [CH*W-1:0] dd,
                       input logic [W-1:0] eo, input logic ev, input logic [CW-1:0] ec,
                       input logic [CH-1:0] ea, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.sel = s; v.d = dd; v.exp_o = eo; v.exp_v = ev;
        v.exp_ch = ec; v.exp_ack = ea; v.exp_st = es;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int acks;
        reset = 1'b1; sel = '0; d = '0; clr_collision = 1'b0;

        // reset with all selects high, then ch0 capture
        add(1, 4'hF, 32'h44332211, 8'h00, 0, 0, 4'h0, 0);
        add(1, 4'hF, 32'h44332211, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'hF, 32'h44332211, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'hF, 32'h44332211, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'hF, 32'h44332211, 8'h11, 1, 0, 4'h1, 1);
        add(0, 4'h0, 32'h44332211, 8'h11, 1, 0, 4'h0, 1);
        add(0, 4'h0, 32'h44332211, 8'h11, 1, 0, 4'h0, 1);
        add(0, 4'h0, 32'h44332211, 8'h00, 0, 0, 4'h0, 2);
        add(0, 4'h0, 32'h44332211, 8'h00, 0, 0, 4'h0, 0);
        // ch2 capture, data change during hold ignored
        add(0, 4'h4, 32'h44A52211, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'h4, 32'h44A52211, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'h4, 32'h44A52211, 8'hA5, 1, 2, 4'h4, 1);
        add(0, 4'h4, 32'h445A2211, 8'hA5, 1, 2, 4'h0, 1);
        add(0, 4'h4, 32'h445A2211, 8'hA5, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h445A2211, 8'hA5, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h445A2211, 8'hA5, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h445A2211, 8'h00, 0, 2, 4'h0, 2);
        add(0, 4'h0, 32'h445A2211, 8'h00, 0, 2, 4'h0, 0);
        // simultaneous ch1/ch2: ch1 wins, ch2 captured after gap
        add(0, 4'h6, 32'h00221100, 8'h00, 0, 2, 4'h0, 0);
        add(0, 4'h6, 32'h00221100, 8'h00, 0, 2, 4'h0, 0);
        add(0, 4'h6, 32'h00221100, 8'h11, 1, 1, 4'h2, 1);
        add(0, 4'h4, 32'h00221100, 8'h11, 1, 1, 4'h0, 1);
        add(0, 4'h4, 32'h00221100, 8'h11, 1, 1, 4'h0, 1);
        add(0, 4'h4, 32'h00221100, 8'h00, 0, 1, 4'h0, 2);
        add(0, 4'h4, 32'h00221100, 8'h00, 0, 1, 4'h0, 0);
        add(0, 4'h4, 32'h00221100, 8'h22, 1, 2, 4'h4, 1);
        add(0, 4'h4, 32'h00221100, 8'h22, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h00221100, 8'h22, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h00221100, 8'h22, 1, 2, 4'h0, 1);
        add(0, 4'h0, 32'h00221100, 8'h00, 0, 2, 4'h0, 2);
        add(0, 4'h0, 32'h77000000, 8'h00, 0, 2, 4'h0, 0);
        // ch3 capture of 0x77, then reset mid-hold
        add(0, 4'h8, 32'h77000000, 8'h00, 0, 2, 4'h0, 0);
        add(0, 4'h8, 32'h77000000, 8'h00, 0, 2, 4'h0, 0);
        add(0, 4'h8, 32'h77000000, 8'h77, 1, 3, 4'h8, 1);
        add(0, 4'h8, 32'h77000000, 8'h77, 1, 3, 4'h0, 1);
        add(1, 4'h8, 32'h77000000, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'h0, 32'h77000000, 8'h00, 0, 0, 4'h0, 0);
        add(0, 4'h0, 32'h77000000, 8'h00, 0, 0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            sel   = vecs[i].sel;
            d     = vecs[i].d;
            step();
            n_tests++;
            if (o !== vecs[i].exp_o || valid !== vecs[i].exp_v || active_ch !== vecs[i].exp_ch ||
                ack !== vecs[i].exp_ack || dbg_state !== vecs[i].exp_st) begin
                n_fail++;
                $display("FAIL vec%0d: got o=%h v=%b ch=%0d ack=%b st=%0d expected o=%h v=%b ch=%0d ack=%b st=%0d",
                         i, o, valid, active_ch, ack, dbg_state, vecs[i].exp_o, vecs[i].exp_v,
                         vecs[i].exp_ch, vecs[i].exp_ack, vecs[i].exp_st);
            end
            if (i == 1) check_bit("reset_collision", collision, 1'b0);
        end

        // long hold on ch3: exactly one ack over 50 cycles
        reset = 1'b0; d = 32'h99000000; sel = 4'h8;
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ack != 4'h0) acks++;
        end
        check_int("long_hold_acks", acks, 1);
        check_bit("long_hold_valid", valid, 1'b1);
        check_int("long_hold_o", int'(o), 'h99);
        sel = 4'h0;
        step(); step();
        check_bit("drop_valid_edge2", valid, 1'b1);
        step();
        check_bit("drop_valid_edge3", valid, 1'b0);
        check_int("drop_o_edge3", int'(o), 0);
        step(); step();

        // multi-select collision flag
        d = 32'h00002211; sel = 4'h3;
        step();
        sel = 4'h0;
        step(); step(); step();
`ifdef COLLISION_DETECT_EN
        check_bit("coll_set", collision, 1'b1);
        step(); step();
        check_bit("coll_sticky", collision, 1'b1);
        sel = 4'h3;
        step(); step(); step();
        clr_collision = 1'b1;
        step(); step();
        check_bit("coll_set_wins", collision, 1'b1);
        clr_collision = 1'b0; sel = 4'h0;
        step(); step(); step();
        clr_collision = 1'b1;
        step();
        clr_collision = 1'b0;
        check_bit("coll_cleared", collision, 1'b0);
`else
        check_bit("coll_tied0", collision, 1'b0);
        sel = 4'h3;
        step(); step(); step();
        check_bit("coll_tied0_held", collision, 1'b0);
        sel = 4'h0;
`endif
        for (int i = 0; i < 6; i++) step();
        check_bit("final_idle_valid", valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
